// File: rtl/bus_read_driver.sv
// Drives one selected source register onto the shared data bus.
// A read snapshots the source and holds it with BusValid for HOLD cycles.
module bus_read_driver #(
    parameter int WIDTH = 8,
    parameter int NSRC  = 6,
    parameter int SEL_W = 3,
    parameter int HOLD  = 2
) (
    input  logic                    Clk,
    input  logic                    RST,
    input  logic                    RdReq,
    input  logic [SEL_W-1:0]        RdSel,
    input  logic [NSRC*WIDTH-1:0]   SrcData,
    output logic [WIDTH-1:0]        BusOut,
    output logic                    BusValid,
    output logic                    Busy,
    output logic                    SelErr
);

    localparam int CNT_W = $clog2(HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD - 1);
    localparam logic [SEL_W:0]   NSRC_EXT = (SEL_W + 1)'(NSRC);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] bus_out_q, bus_out_d;
    logic             bus_valid_q, bus_valid_d;
    logic             busy_q, busy_d;
    logic             sel_err_q, sel_err_d;
    logic             sel_ok;
    logic [WIDTH-1:0] src_sel;

    // Compare one bit wider so NSRC == 2**SEL_W makes every select legal.
    assign sel_ok = ({1'b0, RdSel} < NSRC_EXT);

    always_comb begin
        src_sel = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (sel_q == SEL_W'(i)) begin
                src_sel = SrcData[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        bus_out_d   = bus_out_q;
        bus_valid_d = bus_valid_q;
        busy_d      = busy_q;
        sel_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (RdReq) begin
                    if (sel_ok) begin
                        sel_d   = RdSel;
                        busy_d  = 1'b1;
                        state_d = ST_LOAD;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                bus_out_d   = src_sel;
                bus_valid_d = 1'b1;
                cnt_d       = CNT_LOAD;
                state_d     = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    bus_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                bus_valid_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            bus_out_q   <= '0;
            bus_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            bus_out_q   <= bus_out_d;
            bus_valid_q <= bus_valid_d;
            busy_q      <= busy_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign BusOut   = bus_out_q;
    assign BusValid = bus_valid_q;
    assign Busy     = busy_q;
    assign SelErr   = sel_err_q;

endmodule
